// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_ctrl: 4-digit 7-segment scan controller with blanking and       |
// | 8-level brightness. Revision: 1.0                                         |
// +--------------------------------------------------------------------------+
module seg_scan_ctrl #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] digit_mask,
  input  logic [2:0] brightness,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       slot_start,
  output logic       frame_done
);

  localparam int c_pw   = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int c_ow   = c_pw + 1;
  localparam int c_step = (SLOT_CYCLES - BLANK_CYCLES) / 8;
  localparam logic [c_pw-1:0] c_last  = c_pw'(SLOT_CYCLES - 1);
  localparam logic [c_ow-1:0] c_blank = c_ow'(BLANK_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t          r_state, w_state_n;
  logic [c_pw-1:0] r_phase, w_phase_n;
  logic [1:0]      r_sel, w_sel_n;
  logic [2:0]      r_bri, w_bri_n;
  logic [3:0]      r_mask, w_mask_n;
  logic [3:0]      r_an, w_an_n;
  logic            r_slot_start, w_slot_start_n;
  logic            r_frame_done, w_frame_done_n;
  logic [c_ow-1:0] w_on_len;
  logic [c_ow-1:0] w_phase_x;

  always_comb begin
    w_state_n = r_state;
    w_phase_n = r_phase;
    w_sel_n   = r_sel;
    w_bri_n   = r_bri;
    w_mask_n  = r_mask;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_n = ST_SCAN;
          w_phase_n = '0;
          w_sel_n   = 2'd0;
          w_bri_n   = brightness;
          w_mask_n  = digit_mask;
        end
      end
      ST_SCAN: begin
        // Disable takes priority over the slot wrap.
        if (!en) begin
          w_state_n = ST_IDLE;
          w_phase_n = '0;
          w_sel_n   = 2'd0;
        end else if (r_phase == c_last) begin
          w_phase_n = '0;
          w_sel_n   = r_sel + 2'd1;
          w_bri_n   = brightness;
          w_mask_n  = digit_mask;
        end else begin
          w_phase_n = r_phase + c_pw'(1);
        end
      end
      default: w_state_n = ST_IDLE;
    endcase

    // Outputs are derived from next-state values so the registered outputs
    // line up with the registered phase/sel of the same cycle.
    w_on_len  = c_ow'(c_step) * (c_ow'(w_bri_n) + c_ow'(1));
    w_phase_x = {1'b0, w_phase_n};
    w_an_n    = 4'b1111;
    if ((w_state_n == ST_SCAN) && w_mask_n[w_sel_n] &&
        (w_phase_x >= c_blank) && (w_phase_x < c_blank + w_on_len)) begin
      w_an_n[w_sel_n] = 1'b0;
    end
    w_slot_start_n = (w_state_n == ST_SCAN) && (w_phase_n == '0);
    w_frame_done_n = (w_state_n == ST_SCAN) && (w_sel_n == 2'd3) &&
                     (w_phase_n == c_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_phase      <= '0;
      r_sel        <= 2'd0;
      r_bri        <= 3'd7;
      r_mask       <= 4'b1111;
      r_an         <= 4'b1111;
      r_slot_start <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_phase      <= w_phase_n;
      r_sel        <= w_sel_n;
      r_bri        <= w_bri_n;
      r_mask       <= w_mask_n;
      r_an         <= w_an_n;
      r_slot_start <= w_slot_start_n;
      r_frame_done <= w_frame_done_n;
    end
  end

  assign sel        = r_sel;
  assign an         = r_an;
  assign slot_start = r_slot_start;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (SLOT=20, BLANK=4). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_seg_scan_ctrl;

  localparam int SLOT  = 20;
  localparam int BLANK = 4;
  localparam int STEP  = (SLOT - BLANK) / 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] digit_mask;
  logic [2:0] brightness;
  logic [1:0] sel;
  logic [3:0] an;
  logic       slot_start;
  logic       frame_done;

  seg_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digit_mask (digit_mask),
    .brightness (brightness),
    .sel        (sel),
    .an         (an),
    .slot_start (slot_start),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] an;
    logic       ss;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       m_run;
  int         m_ph;
  logic [1:0] m_sel;
  logic [2:0] m_bri;
  logic [3:0] m_mask;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_ph   = 0;
    m_sel  = 2'd0;
    m_bri  = 3'd7;
    m_mask = 4'b1111;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.sel = m_sel;
    e.an  = 4'b1111;
    if (m_run && m_mask[m_sel] && m_ph >= BLANK &&
        m_ph < BLANK + STEP * (int'(m_bri) + 1))
      e.an[m_sel] = 1'b0;
    e.ss = m_run && (m_ph == 0);
    e.fd = m_run && (m_sel == 2'd3) && (m_ph == SLOT - 1);
    return e;
  endfunction

  // Advance the model by the coming edge, then compare after that edge.
  task automatic tick();
    exp_t e;
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1; m_ph = 0; m_sel = 2'd0;
        m_bri = brightness; m_mask = digit_mask;
      end
    end else if (!en) begin
      m_run = 1'b0; m_ph = 0; m_sel = 2'd0;
    end else if (m_ph == SLOT - 1) begin
      m_ph = 0; m_sel = m_sel + 2'd1;
      m_bri = brightness; m_mask = digit_mask;
    end else begin
      m_ph++;
    end
    q.push_back(model_out());
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("sel", {6'd0, sel}, {6'd0, e.sel});
    chk("an", {4'd0, an}, {4'd0, e.an});
    chk("slot_start", {7'd0, slot_start}, {7'd0, e.ss});
    chk("frame_done", {7'd0, frame_done}, {7'd0, e.fd});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until(input logic [1:0] s, input int p);
    int budget;
    budget = 0;
    while (!(m_run && m_sel == s && m_ph == p) && budget < 200) begin
      tick();
      budget++;
    end
    if (budget >= 200) begin
      n_cmp++;
      n_bad++;
      $error("FAIL run_until observed=timeout expected=sel%0d/phase%0d", s, p);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; brightness = 3'd7; digit_mask = 4'b1111;
    model_reset();
    #12;
    chk("rst_sel", {6'd0, sel}, 8'h00);
    chk("rst_an", {4'd0, an}, 8'h0F);
    chk("rst_ss", {7'd0, slot_start}, 8'h00);
    chk("rst_fd", {7'd0, frame_done}, 8'h00);
    rst_n = 1'b1;
    run(3);

    // Full brightness, all digits
    en = 1'b1;
    tick();
    chk("start_ss", {7'd0, slot_start}, 8'h01);
    run(180);

    brightness = 3'd0; run(100);
    brightness = 3'd3; run(100);
    brightness = 3'd7; digit_mask = 4'b0101; run(100);

    // Brightness drop mid-slot 1 applies from slot 2
    digit_mask = 4'b1111;
    run_until(2'd0, 0);
    run_until(2'd1, 8);
    brightness = 3'd0;
    run(40);

    // Enable dropped mid-slot 2
    brightness = 3'd7;
    run_until(2'd2, 10);
    en = 1'b0;
    tick();
    chk("stop_an", {4'd0, an}, 8'h0F);
    chk("stop_sel", {6'd0, sel}, 8'h00);
    run(3);
    en = 1'b1;
    tick();
    chk("restart_ss", {7'd0, slot_start}, 8'h01);

    // Enable dropped on the frame-wrap edge
    run_until(2'd3, SLOT - 1);
    chk("wrap_fd", {7'd0, frame_done}, 8'h01);
    en = 1'b0;
    tick();
    chk("wrap_stop_fd", {7'd0, frame_done}, 8'h00);
    en = 1'b1;
    run(2);

    // Asynchronous reset inside an on-window
    run_until(2'd0, 10);
    chk("pre_rst_an", {4'd0, an}, 8'h0E);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_an", {4'd0, an}, 8'h0F);
    chk("arst_sel", {6'd0, sel}, 8'h00);
    chk("arst_ss", {7'd0, slot_start}, 8'h00);
    en = 1'b0;
    #2;
    rst_n = 1'b1;
    run(5);
    en = 1'b1;
    run(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
